// File: rtl/scr1_tapc_master.sv
// JTAG TAP controller master: runs one DR scan, IR scan or TAP reset per accepted request,
// bit-banging TCK/TMS/TDI from the system clock and capturing TDO into resp_data.
module scr1_tapc_master #(
   parameter int unsigned SCR1_MAX_LEN = 32,
   parameter int unsigned SCR1_TCK_DIV = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req_vld,
   output logic                    req_rdy,
   input  logic [1:0]              req_op,
   input  logic [5:0]              req_len,
   input  logic [SCR1_MAX_LEN-1:0] req_data,
   output logic                    resp_vld,
   output logic [SCR1_MAX_LEN-1:0] resp_data,
   output logic                    tck,
   output logic                    tms,
   output logic                    tdi,
   input  logic                    tdo
);

   localparam int unsigned LW = $clog2(SCR1_MAX_LEN + 1);
   // Counter also walks the up-to-5-period PRE sequence, so never narrower than 3 bits.
   localparam int unsigned CW = (LW > 3) ? LW : 3;
   localparam int unsigned DW = $clog2(2 * SCR1_TCK_DIV);

   localparam logic [1:0] OpIr  = 2'b01;
   localparam logic [1:0] OpRst = 2'b10;

   typedef enum logic [2:0] {StIdle, StPre, StShift, StPost, StResp} state_t;

   state_t                  state_q, state_d;
   logic [1:0]              op_q, op_d;
   logic [CW-1:0]           len_q, len_d, len_sat;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [DW-1:0]           div_q, div_d;
   logic [SCR1_MAX_LEN-1:0] data_q, data_d;
   logic [SCR1_MAX_LEN-1:0] cap_q, cap_d;
   logic [SCR1_MAX_LEN-1:0] resp_data_q, resp_data_d;
   logic                    tck_q, tck_d;
   logic                    tms_q, tms_d;
   logic                    tdi_q, tdi_d;

   // Number of TCK periods spent in a scan phase.
   function automatic logic [CW-1:0] period_cnt(state_t st, logic [1:0] op, logic [CW-1:0] len);
      case (st)
         StPre:   return (op == OpIr) ? CW'(4) : (op == OpRst) ? CW'(5) : CW'(3);
         StShift: return len;
         StPost:  return (op == OpRst) ? CW'(1) : CW'(2);
         default: return CW'(1);
      endcase
   endfunction

   function automatic logic tms_of(state_t st, logic [1:0] op, logic [CW-1:0] cnt,
                                   logic [CW-1:0] len);
      case (st)
         StPre: begin
            case (op)
               OpIr:    return cnt < CW'(2);
               OpRst:   return 1'b1;
               default: return cnt == '0;
            endcase
         end
         StShift: return cnt == (len - 1'b1);
         StPost:  return (op != OpRst) && (cnt == '0);
         default: return 1'b0;
      endcase
   endfunction

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      div_d       = div_q;
      data_d      = data_q;
      cap_d       = cap_q;
      resp_data_d = resp_data_q;
      tck_d       = tck_q;
      tms_d       = tms_q;
      tdi_d       = tdi_q;
      len_sat     = (32'(req_len) > SCR1_MAX_LEN) ? CW'(SCR1_MAX_LEN) : CW'(req_len);

      unique case (state_q)
         StIdle: begin
            if (req_vld) begin
               op_d   = req_op;
               len_d  = len_sat;
               data_d = req_data;
               cap_d  = '0;
               cnt_d  = '0;
               div_d  = '0;
               tck_d  = 1'b0;
               tdi_d  = 1'b0;
               if ((len_sat == '0) || (req_op == 2'b11)) begin
                  state_d     = StResp;
                  resp_data_d = '0;
               end else begin
                  state_d = StPre;
                  tms_d   = 1'b1;
               end
            end
         end
         StPre, StShift, StPost: begin
            div_d = (div_q == DW'(2 * SCR1_TCK_DIV - 1)) ? '0 : div_q + 1'b1;
            if (div_q == DW'(SCR1_TCK_DIV - 1)) begin
               tck_d = 1'b1;
               if (state_q == StShift) begin
                  for (int unsigned i = 0; i < SCR1_MAX_LEN; i++) begin
                     if (cnt_q == CW'(i)) cap_d[i] = tdo;
                  end
               end
            end
            if (div_q == DW'(2 * SCR1_TCK_DIV - 1)) begin
               tck_d = 1'b0;
               if (cnt_q == (period_cnt(state_q, op_q, len_q) - 1'b1)) begin
                  cnt_d = '0;
                  case (state_q)
                     StPre:   state_d = (op_q == OpRst) ? StPost : StShift;
                     StShift: state_d = StPost;
                     default: state_d = StResp;
                  endcase
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
               // TMS/TDI for the next period are launched on this falling edge.
               tms_d = tms_of(state_d, op_q, cnt_d, len_q);
               tdi_d = 1'b0;
               if (state_d == StShift) begin
                  for (int unsigned i = 0; i < SCR1_MAX_LEN; i++) begin
                     if (cnt_d == CW'(i)) tdi_d = data_q[i];
                  end
               end
               if (state_d == StResp) resp_data_d = cap_q;
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         op_q        <= '0;
         len_q       <= '0;
         cnt_q       <= '0;
         div_q       <= '0;
         data_q      <= '0;
         cap_q       <= '0;
         resp_data_q <= '0;
         tck_q       <= 1'b0;
         tms_q       <= 1'b1;
         tdi_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         div_q       <= div_d;
         data_q      <= data_d;
         cap_q       <= cap_d;
         resp_data_q <= resp_data_d;
         tck_q       <= tck_d;
         tms_q       <= tms_d;
         tdi_q       <= tdi_d;
      end
   end

   assign req_rdy   = (state_q == StIdle);
   assign resp_vld  = (state_q == StResp);
   assign resp_data = resp_data_q;
   assign tck       = tck_q;
   assign tms       = tms_q;
   assign tdi       = tdi_q;

endmodule
